wb_regfile: RTL



---
 rtl/rv_pkg.sv | 8 +
 rtl/regfile_read_port.sv | 15 +
 rtl/wb_regfile.sv | 48 ++++
 3 files changed

// File: rtl/rv_pkg.sv
// rv_pkg: shared register-file widths, zero index and register word type
package rv_pkg;
  localparam int XLEN = 32;
  localparam int REG_IDX_W = 5;
  localparam int NREGS = 32;
  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;
  typedef logic [XLEN-1:0] word_t;
endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: zero-forced, optionally bypassed read of the flattened register array
module regfile_read_port
  import rv_pkg::*;
(
  input  logic [REG_IDX_W-1:0]  addr,
  input  logic [NREGS*XLEN-1:0] regs_flat,
  input  logic                  byp_en,
  input  logic [REG_IDX_W-1:0]  byp_rd,
  input  logic [XLEN-1:0]       byp_data,
  output logic [XLEN-1:0]       data
);
  assign data = addr == REG_ZERO ? '0 :
                (byp_en && byp_rd == addr) ? byp_data :
                regs_flat[addr*XLEN +: XLEN];
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: integer register file with x0 hardwired to zero and a wrapping write counter
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data onto colliding reads.
module wb_regfile
  import rv_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic [XLEN-1:0]      wb_data,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic                 wb_reg_en,
  input  logic [REG_IDX_W-1:0] rs1_addr,
  input  logic [REG_IDX_W-1:0] rs2_addr,
  output logic [XLEN-1:0]      rs1_data,
  output logic [XLEN-1:0]      rs2_data,
  output logic [15:0]          wr_count
);
  word_t regs [1:NREGS-1];
  logic [NREGS*XLEN-1:0] regs_flat;
  logic wr;
  logic byp_en;
  assign wr = wb_reg_en && wb_rd != REG_ZERO;
`ifdef REGFILE_BYPASS_EN
  assign byp_en = wr && !reset;
`else
  assign byp_en = 1'b0;
`endif
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      for (int i = 1; i < NREGS; i++) regs[i] <= '0;
      wr_count <= '0;
    end else if (wr) begin
      regs[wb_rd] <= wb_data;
      wr_count <= wr_count + 16'd1;
    end
  // slot 0 of the flattened view is a constant so x0 costs no storage
  assign regs_flat[XLEN-1:0] = '0;
  for (genvar g = 1; g < NREGS; g++) begin : g_flat
    assign regs_flat[g*XLEN +: XLEN] = regs[g];
  end
  regfile_read_port u_rs1 (
    .addr(rs1_addr), .regs_flat(regs_flat), .byp_en(byp_en),
    .byp_rd(wb_rd), .byp_data(wb_data), .data(rs1_data)
  );
  regfile_read_port u_rs2 (
    .addr(rs2_addr), .regs_flat(regs_flat), .byp_en(byp_en),
    .byp_rd(wb_rd), .byp_data(wb_data), .data(rs2_data)
  );
endmodule
